alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 4-bit add/sub ALU instance (`alu`: inputs A, B, Sel; output Res) among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready request port per requester and a single shared response channel tagged with the requester id.
- Exactly one operation in flight; operands and result are registered, so the ALU sees stable inputs for a full cycle.
- Sits between the instruction/issue logic and the ALU datapath.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  [NUM_REQ-1:0]  per-requester operation request.
- req_a  input  [NUM_REQ-1:0][3:0]  operand A per requester.
- req_b  input  [NUM_REQ-1:0][3:0]  operand B per requester.
- req_sel  input  [NUM_REQ-1:0]  per-requester op select; 0 = A-B, 1 = A+B.
- req_ready  output  [NUM_REQ-1:0]  one-hot accept; at most one bit high.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  response consumer accepts the result.
- rsp_data  output  4  ALU result.
- rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the result.
- busy  output  1  high when state != IDLE.
- done_count  output  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = IDLE; rsp_valid = 0; rsp_data = 0; rsp_id = 0; done_count = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - req_ready = 0 and busy = 0 during reset and in the cycle after it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready[pick] = 1 combinationally in the same cycle; all other req_ready bits are 0.
  - At the clock edge, capture req_a/req_b/req_sel[pick] into operand registers and pick into gnt_id; go to EXEC.
  - If no req_valid is set: stay in IDLE with req_ready = 0.
- EXEC:
  - The ALU is driven from the operand registers.
  - At the clock edge: rsp_data <= Res, rsp_id <= gnt_id, rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_id are held stable until rsp_ready = 1.
  - At an edge where rsp_ready = 1: rsp_valid <= 0, last_grant <= gnt_id, done_count increments; go to IDLE.
  - If rsp_ready = 0: stay in RESP indefinitely.
- Latency and throughput:
  - Accept in cycle T; rsp_valid first high in cycle T+2.
  - Minimum spacing between accepts is 3 cycles (rsp_ready held at 1).
- req_ready is 0 in EXEC and RESP. New requests wait; they are never queued internally.
- Arithmetic follows the ALU exactly:
  - 4-bit result, modulo 16, no carry or borrow output.
  - Sel = 0 computes A-B (e.g. 2-5 = 4'hD); Sel = 1 computes A+B (e.g. 9+8 = 4'h1).
- Requester obligations:
  - May drop req_valid before it is granted; there is no side effect.
  - Must hold its operands stable while req_valid is high.
  - req_valid must not depend on req_ready.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants to other requesters.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped, no response is produced, and done_count returns to 0.
- done_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package alu_arbiter_pkg holds:
  - state enum (IDLE, EXEC, RESP);
  - ALU_W = 4;
  - SEL_SUB = 1'b0 and SEL_ADD = 1'b1.
- Sub-module alu_rr_pick: combinational round-robin picker.
  - Inputs: req vector, last_grant. Outputs: pick index, any_valid.
- The existing alu module is instantiated unchanged.

Test Plan:
- Reset check: after reset, only req_valid = 2'b01 with A=3, B=1, sel=1 -> req_ready = 2'b01 in that cycle; two cycles later rsp_valid = 1, rsp_data = 4, rsp_id = 0.
- Wrap-around: req0 A=2, B=5, sel=0 -> rsp_data = 4'hD. req1 A=9, B=8, sel=1 -> rsp_data = 4'h1.
- Round-robin: both requesters hold valid continuously with rsp_ready = 1 -> grants alternate 0,1,0,1; done_count = 4 after 12 cycles.
- Backpressure: rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_data and rsp_id held stable, req_ready = 0 throughout, busy = 1. Raising rsp_ready completes the transaction, and the next grant follows in the IDLE cycle after.
- Reset mid-op: reset asserted in EXEC -> no rsp_valid ever appears; next cycle state = IDLE and done_count = 0; a subsequent req1-only request is granted normally.
- Counter wrap: with CNT_W = 2, perform 5 transactions -> done_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the round-robin ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned ALU_W = 4;

  localparam logic SEL_SUB = 1'b0;
  localparam logic SEL_ADD = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/alu.sv
// Existing 4-bit add/sub ALU: Sel = 0 computes A-B, Sel = 1 computes A+B, modulo 16.
module alu (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Sel,
  output logic [3:0] Res
);

  assign Res = Sel ? (A + B) : (A - B);

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_i+1.
module alu_rr_pick #(
  parameter int unsigned NumReq = 2
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] last_i,
  output logic [$clog2(NumReq)-1:0] pick_o,
  output logic                      any_o
);

  localparam int unsigned IdW = $clog2(NumReq);

  always_comb begin
    logic [IdW-1:0] idx;
    pick_o = '0;
    any_o  = 1'b0;
    idx    = '0;
    // k = NumReq revisits last_i itself, so a lone repeat requester still wins.
    for (int unsigned k = 1; k <= NumReq; k++) begin
      idx = IdW'((32'(last_i) + k) % NumReq);
      if (!any_o && req_i[idx]) begin
        any_o  = 1'b1;
        pick_o = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered add/sub ALU among NUM_REQ requesters,
// with one operation in flight and a single id-tagged response channel.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]     req_a,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]     req_b,
  input  logic [NUM_REQ-1:0]                req_sel,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [ALU_W-1:0]                  rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic                              busy,
  output logic [CNT_W-1:0]                  done_count
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  state_e             state_q;
  logic [ALU_W-1:0]   a_q, b_q;
  logic               sel_q;
  logic [IdW-1:0]     gnt_q;
  logic [IdW-1:0]     last_q;
  logic [ALU_W-1:0]   rsp_data_q;
  logic [IdW-1:0]     rsp_id_q;
  logic               rsp_valid_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               hold_q;

  logic [IdW-1:0]     pick;
  logic               any_req;
  logic [ALU_W-1:0]   alu_res;
  logic               grant;

  alu_rr_pick #(
    .NumReq (NUM_REQ)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  alu u_alu (
    .A   (a_q),
    .B   (b_q),
    .Sel (sel_q),
    .Res (alu_res)
  );

  // hold_q keeps the port closed for the first cycle after reset.
  assign grant      = (state_q == StIdle) && any_req && !hold_q && !reset;
  assign req_ready  = grant ? (NUM_REQ'(1) << pick) : '0;
  assign busy       = (state_q != StIdle) && !reset;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign done_count = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= SEL_SUB;
      gnt_q       <= '0;
      last_q      <= IdW'(NUM_REQ - 1);
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= 1'b1;
    end else begin
      hold_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            a_q     <= req_a[pick];
            b_q     <= req_b[pick];
            sel_q   <= req_sel[pick];
            gnt_q   <= pick;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_data_q  <= alu_res;
          rsp_id_q    <= gnt_q;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            last_q      <= gnt_q;
            cnt_q       <= cnt_q + CNT_W'(1);
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction scoreboard and a second
// instance using a 2-bit counter to exercise done_count wrap.
module tb_alu_arbiter;

  localparam int unsigned NUM_REQ = 2;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0][3:0]      req_a, req_b;
  logic [NUM_REQ-1:0]           req_sel;
  logic                         rsp_ready;

  logic [NUM_REQ-1:0]           req_ready, req_ready2;
  logic                         rsp_valid, rsp_valid2;
  logic [3:0]                   rsp_data, rsp_data2;
  logic [0:0]                   rsp_id, rsp_id2;
  logic                         busy, busy2;
  logic [7:0]                   done_count;
  logic [1:0]                   done_count2;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_sel(req_sel), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .done_count(done_count)
  );

  alu_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_sel(req_sel), .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data2), .rsp_id(rsp_id2), .busy(busy2), .done_count(done_count2)
  );

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 = idle, 1 = executing, 2 = response pending.
  int   m_phase = 0;
  int   m_last  = NUM_REQ - 1;
  int   m_gnt   = 0;
  int   m_cnt   = 0;
  bit   m_hold  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return 0;
  endfunction

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic sel);
    return sel ? 4'(a + b) : 4'(a - b);
  endfunction

  // One clock: check at the falling edge, advance the model, then step past the rising edge.
  task automatic tick();
    int   p;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    if (reset) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      m_phase = 0;
      m_hold  = 1'b1;
      m_cnt   = 0;
      m_last  = NUM_REQ - 1;
      sb.delete();
    end else begin
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      chk("done_count", 32'(done_count), 32'(m_cnt % 256));
      chk("done_count_w2", 32'(done_count2), 32'(m_cnt % 4));
      exp_rdy = '0;
      case (m_phase)
        0: begin
          if (!m_hold && req_valid != '0) begin
            p       = rr_pick(req_valid, m_last);
            exp_rdy = NUM_REQ'(1) << p;
            sb.push_back('{id: 4'(p), data: alu_ref(req_a[p], req_b[p], req_sel[p])});
            m_gnt   = p;
            m_phase = 1;
          end
          chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        end
        1: begin
          chk("req_ready_exec", 32'(req_ready), 0);
          m_phase = 2;
        end
        default: begin
          chk("req_ready_resp", 32'(req_ready), 0);
          chk("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
            chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            if (rsp_ready) begin
              void'(sb.pop_front());
              m_last = m_gnt;
              m_cnt++;
              m_phase = 0;
            end
          end
        end
      endcase
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [3:0] a, input logic [3:0] b,
                        input logic sel);
    req_a[r]   = a;
    req_b[r]   = b;
    req_sel[r] = sel;
  endtask

  // Single request from requester r: granted in the first tick, answered in the third.
  task automatic do_op(input int r, input logic [3:0] a, input logic [3:0] b,
                       input logic sel);
    set_op(r, a, b, sel);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    int start_cnt;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    req_valid = 2'b01;
    set_op(0, 4'd3, 4'd1, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    tick();                      // post-reset cycle: no accept
    tick();                      // grant req0
    req_valid = '0;
    tick();
    tick();                      // 3+1 = 4 from id 0

    do_op(0, 4'd2, 4'd5, 1'b0);  // 2-5 = D
    do_op(1, 4'd9, 4'd8, 1'b1);  // 9+8 = 1

    // Round robin with both requesting.
    set_op(0, 4'd7, 4'd4, 1'b0);
    set_op(1, 4'd6, 4'd6, 1'b1);
    req_valid = 2'b11;
    start_cnt = m_cnt;
    for (int i = 0; i < 12; i++) tick();
    chk("rr_done_count", 32'(done_count), 32'((start_cnt + 4) % 256));
    req_valid = '0;

    // Backpressure for 5 cycles, with another requester waiting.
    rsp_ready = 1'b0;
    set_op(0, 4'd15, 4'd1, 1'b1);
    req_valid = 2'b01;
    tick();
    set_op(1, 4'd1, 4'd2, 1'b0);
    req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rsp_ready = 1'b1;
    tick();                      // accepted
    tick();                      // req1 granted in the following idle cycle
    req_valid = '0;
    tick();
    tick();

    // Reset while executing.
    set_op(1, 4'd5, 4'd3, 1'b0);
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_done_count", 32'(done_count), 0);
    tick();
    do_op(1, 4'd4, 4'd4, 1'b1);

    // Counter wrap on the 2-bit instance: 1,2,3,0,1 after reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) do_op(i % 2, 4'(i), 4'(3 * i), 1'(i % 2));
    chk("wrap_done_count_w2", 32'(done_count2), 1);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
